// File: rtl/eight_bit_demux_dispatch_ctrl.sv
// Byte dispatch controller: holds one byte and routes it through an 8-bit 1-to-4 demux into per-channel output slots.
// Optional broadcast dispatch is enabled by defining DEMUX_BCAST_EN.

module eight_bit_demux_1to4 (
  input  logic [7:0] a,
  input  logic [1:0] s,
  output logic [7:0] y0,
  output logic [7:0] y1,
  output logic [7:0] y2,
  output logic [7:0] y3
);
  logic s0_n, s1_n, e0, e1, e2, e3;

  not u_n0 (s0_n, s[0]);
  not u_n1 (s1_n, s[1]);
  and u_e0 (e0, s1_n, s0_n);
  and u_e1 (e1, s1_n, s[0]);
  and u_e2 (e2, s[1], s0_n);
  and u_e3 (e3, s[1], s[0]);

  genvar i;
  generate
    for (i = 0; i < 8; i++) begin : g_bit
      and u_y0 (y0[i], a[i], e0);
      and u_y1 (y1[i], a[i], e1);
      and u_y2 (y2[i], a[i], e2);
      and u_y3 (y3[i], a[i], e3);
    end
  endgenerate
endmodule

module eight_bit_demux_dispatch_ctrl #(
  parameter int STALL_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [1:0] in_dest,
  input  logic       in_bcast,
  output logic [3:0] out_valid,
  input  logic [3:0] out_ready,
  output logic [7:0] out_data0,
  output logic [7:0] out_data1,
  output logic [7:0] out_data2,
  output logic [7:0] out_data3,
  output logic [1:0] demux_sel,
  output logic [7:0] disp_cnt,
  output logic       stall_err
);
  localparam logic [7:0] STALL_LIM = 8'(STALL_MAX);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
  state_t state, state_nxt;

  logic [7:0] hold_data;
  logic [7:0] stall_cnt;
  logic [7:0] stall_nxt;
  logic [7:0] dmx_a;
  logic [7:0] dmx_y [4];
  logic [7:0] slot_data [4];
  logic [3:0] can_load;
  logic [3:0] load;
  logic       accept;
  logic       dispatch;
  logic       bcast_sel;

`ifdef DEMUX_BCAST_EN
  logic hold_bcast;
  assign bcast_sel = hold_bcast;
`else
  logic unused_bcast;
  assign unused_bcast = in_bcast;
  assign bcast_sel    = 1'b0;
`endif

  // a slot accepts new data when empty or being drained this cycle
  assign can_load  = ~out_valid | out_ready;
  assign dmx_a     = (state == HOLD) ? hold_data : 8'h00;
  assign stall_nxt = (stall_cnt == 8'hFF) ? 8'hFF : stall_cnt + 8'd1;

  eight_bit_demux_1to4 u_demux (
    .a  (dmx_a),
    .s  (demux_sel),
    .y0 (dmx_y[0]),
    .y1 (dmx_y[1]),
    .y2 (dmx_y[2]),
    .y3 (dmx_y[3])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = HOLD;
      HOLD:    if (dispatch) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    accept   = in_ready & in_valid;
    dispatch = 1'b0;
    load     = 4'b0000;
    if (state == HOLD) begin
      if (bcast_sel) begin
        dispatch = &can_load;
        load     = {4{dispatch}};
      end else begin
        dispatch        = can_load[demux_sel];
        load[demux_sel] = dispatch;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data <= 8'h00;
`ifdef DEMUX_BCAST_EN
      hold_bcast <= 1'b0;
`endif
      demux_sel <= 2'b00;
      out_valid <= 4'b0000;
      for (int k = 0; k < 4; k++) slot_data[k] <= 8'h00;
      disp_cnt  <= 8'h00;
      stall_cnt <= 8'h00;
      stall_err <= 1'b0;
    end else begin
      if (accept) begin
        hold_data <= in_data;
        demux_sel <= in_dest;
`ifdef DEMUX_BCAST_EN
        hold_bcast <= in_bcast;
`endif
      end
      for (int k = 0; k < 4; k++) begin
        if (load[k]) begin
          out_valid[k] <= 1'b1;
          slot_data[k] <= bcast_sel ? hold_data : dmx_y[k];
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
      if (dispatch) disp_cnt <= disp_cnt + 8'd1;
      // stall_err rises on the same edge the counter reaches the limit
      if (accept) begin
        stall_cnt <= 8'h00;
      end else if ((state == HOLD) && !dispatch) begin
        stall_cnt <= stall_nxt;
        if (stall_nxt == STALL_LIM) stall_err <= 1'b1;
      end
    end
  end

  assign out_data0 = slot_data[0];
  assign out_data1 = slot_data[1];
  assign out_data2 = slot_data[2];
  assign out_data3 = slot_data[3];
endmodule

// File: tb/tb_eight_bit_demux_dispatch_ctrl.sv
// Bench for eight_bit_demux_dispatch_ctrl: a transaction-level model checked every cycle plus directed literal checks.
module tb_eight_bit_demux_dispatch_ctrl;
  localparam int STALL_MAX = 15;
`ifdef DEMUX_BCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_bcast;
  logic [7:0] in_data;
  logic [1:0] in_dest;
  logic [3:0] out_valid, out_ready;
  logic [7:0] out_data0, out_data1, out_data2, out_data3;
  logic [1:0] demux_sel;
  logic [7:0] disp_cnt;
  logic       stall_err;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  eight_bit_demux_dispatch_ctrl #(.STALL_MAX(STALL_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dest(in_dest), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
    .demux_sel(demux_sel), .disp_cnt(disp_cnt), .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: one held byte, four slots, counters kept as plain integers
  bit         m_busy = 0;
  bit         m_bc = 0;
  logic [7:0] m_byte = 8'h00;
  int         m_dest = 0;
  logic [3:0] m_v = 4'b0000;
  logic [7:0] m_d [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  int         m_cnt = 0;
  int         m_stall = 0;
  bit         m_err = 0;
  logic [3:0] m_free;
  bit         m_go;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_bc = 0; m_byte = 8'h00; m_dest = 0; m_v = 4'b0000;
      for (int k = 0; k < 4; k++) m_d[k] = 8'h00;
      m_cnt = 0; m_stall = 0; m_err = 0;
    end else if (m_busy) begin
      m_free = ~m_v | out_ready;
      m_go   = m_bc ? (m_free == 4'hF) : m_free[m_dest];
      m_v    = m_v & ~out_ready;
      if (m_go) begin
        for (int k = 0; k < 4; k++)
          if (m_bc || k == m_dest) begin m_v[k] = 1'b1; m_d[k] = m_byte; end
        m_cnt  = (m_cnt + 1) % 256;
        m_busy = 0;
      end else begin
        if (m_stall < 255) m_stall++;
        if (m_stall == STALL_MAX) m_err = 1;
      end
    end else begin
      m_v = m_v & ~out_ready;
      if (in_valid) begin
        m_busy = 1; m_byte = in_data; m_dest = int'(in_dest);
        m_bc = BCAST && in_bcast; m_stall = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", {31'b0, in_ready}, {31'b0, !m_busy});
      check("out_valid", {28'b0, out_valid}, {28'b0, m_v});
      check("out_data0", {24'b0, out_data0}, {24'b0, m_d[0]});
      check("out_data1", {24'b0, out_data1}, {24'b0, m_d[1]});
      check("out_data2", {24'b0, out_data2}, {24'b0, m_d[2]});
      check("out_data3", {24'b0, out_data3}, {24'b0, m_d[3]});
      check("demux_sel", {30'b0, demux_sel}, m_dest);
      check("disp_cnt", {24'b0, disp_cnt}, m_cnt);
      check("stall_err", {31'b0, stall_err}, {31'b0, m_err});
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] dst);
    in_valid = 1'b1; in_data = d; in_dest = dst; in_bcast = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0; #1; rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_bcast = 1'b0; in_data = 8'h00; in_dest = 2'd0; out_ready = 4'b0000;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    tick(); tick();
    check("rst_in_ready", {31'b0, in_ready}, 1);
    check("rst_out_valid", {28'b0, out_valid}, 0);
    check("rst_disp_cnt", {24'b0, disp_cnt}, 0);
    rst_n = 1'b1;
    tick();

    // single dispatch, minimum latency
    in_valid = 1'b1; in_data = 8'hA5; in_dest = 2'd2;
    tick();
    check("acc_in_ready", {31'b0, in_ready}, 0);
    in_valid = 1'b0;
    tick();
    check("a5_out_valid", {28'b0, out_valid}, 32'h4);
    check("a5_out_data2", {24'b0, out_data2}, 32'hA5);
    check("a5_disp_cnt", {24'b0, disp_cnt}, 1);
    check("a5_in_ready", {31'b0, in_ready}, 1);

    // stall on blocked slot 1, then release
    send(8'h01, 2'd1);
    in_valid = 1'b1; in_data = 8'h3C; in_dest = 2'd1;
    tick();
    in_valid = 1'b0;
    repeat (14) tick();
    check("stall14_err", {31'b0, stall_err}, 0);
    tick();
    check("stall15_err", {31'b0, stall_err}, 1);
    check("stall_in_ready", {31'b0, in_ready}, 0);
    out_ready = 4'b0010;
    tick();
    out_ready = 4'b0000;
    check("rel_out_data1", {24'b0, out_data1}, 32'h3C);
    check("rel_in_ready", {31'b0, in_ready}, 1);
    check("rel_stall_err", {31'b0, stall_err}, 1);

    // drain and load of slot 0 on the same edge
    send(8'h11, 2'd0);
    in_valid = 1'b1; in_data = 8'h22; in_dest = 2'd0;
    tick();
    in_valid = 1'b0; out_ready = 4'b0001;
    tick();
    out_ready = 4'b0000;
    check("dl_out_valid0", {31'b0, out_valid[0]}, 1);
    check("dl_out_data0", {24'b0, out_data0}, 32'h22);

    // broadcast request with slot 3 blocked
    pulse_reset();
    send(8'h33, 2'd3);
    in_valid = 1'b1; in_data = 8'h5A; in_dest = 2'd2; in_bcast = 1'b1;
    tick();
    in_valid = 1'b0; in_bcast = 1'b0;
`ifdef DEMUX_BCAST_EN
    repeat (3) tick();
    check("bc_wait_valid", {28'b0, out_valid}, 32'h8);
    check("bc_wait_cnt", {24'b0, disp_cnt}, 1);
    out_ready = 4'b1000;
    tick();
    out_ready = 4'b0000;
    check("bc_out_valid", {28'b0, out_valid}, 32'hF);
    check("bc_out_data0", {24'b0, out_data0}, 32'h5A);
    check("bc_out_data3", {24'b0, out_data3}, 32'h5A);
    check("bc_disp_cnt", {24'b0, disp_cnt}, 2);
`else
    tick();
    check("nobc_out_valid", {28'b0, out_valid}, 32'hC);
    check("nobc_out_data2", {24'b0, out_data2}, 32'h5A);
    check("nobc_out_data3", {24'b0, out_data3}, 32'h33);
    check("nobc_disp_cnt", {24'b0, disp_cnt}, 2);
`endif

    // 256 back-to-back dispatches wrap the counter
    pulse_reset();
    out_ready = 4'b1111;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; in_data = 8'(i) ^ 8'h5C; in_dest = 2'(i % 4);
      tick(); tick();
      if (i == 254) check("cnt_255", {24'b0, disp_cnt}, 255);
    end
    in_valid = 1'b0;
    check("wrap_disp_cnt", {24'b0, disp_cnt}, 0);
    check("wrap_out_valid", {28'b0, out_valid}, 32'h8);
    check("wrap_out_data3", {24'b0, out_data3}, 32'hA3);
    out_ready = 4'b0000;
    tick();

    // reset while holding 8'h77
    pulse_reset();
    send(8'h33, 2'd3);
    in_valid = 1'b1; in_data = 8'h77; in_dest = 2'd3;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0; #1;
    check("hr_in_ready", {31'b0, in_ready}, 1);
    check("hr_out_valid", {28'b0, out_valid}, 0);
    check("hr_out_data3", {24'b0, out_data3}, 0);
    check("hr_demux_sel", {30'b0, demux_sel}, 0);
    check("hr_disp_cnt", {24'b0, disp_cnt}, 0);
    rst_n = 1'b1;
    tick();
    check("hr_first_ready", {31'b0, in_ready}, 1);
    tick();
    check("hr_no_77", {24'b0, out_data3}, 0);
    check("hr_valid_after", {28'b0, out_valid}, 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/eight_bit_demux_dispatch_ctrl.md
EIGHT_BIT_DEMUX_DISPATCH_CTRL -- requirements
Module: eight_bit_demux_dispatch_ctrl

Interface
REQ-001 Parameter STALL_MAX, default 15, stall-cycle count (1..255) at which stall_err sets.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream byte valid.
REQ-005 in_ready  output  1  controller can accept a byte.
REQ-006 in_data  input  8  byte to dispatch.
REQ-007 in_dest  input  2  destination channel 0..3.
REQ-008 in_bcast  input  1  broadcast request; ignored unless DEMUX_BCAST_EN is defined.
REQ-009 out_valid  output  4  per-channel slot valid, bit k = channel k.
REQ-010 out_ready  input  4  per-channel consumer ready, bit k = channel k.
REQ-011 out_data0, out_data1, out_data2, out_data3  output  8 each  per-channel slot data.
REQ-012 demux_sel  output  2  select currently driven to the demux datapath.
REQ-013 disp_cnt  output  8  completed-dispatch counter.
REQ-014 stall_err  output  1  sticky stall-limit flag.

Function
REQ-015 Datapath SHALL route the held byte through one instance of the team's 8-bit 1-to-4 gate-level demux, with a = held byte in HOLD and 8'h00 in IDLE, s = demux_sel.
REQ-016 FSM SHALL have two states: IDLE and HOLD; in_ready = 1 exactly in IDLE.
REQ-017 IDLE: in_valid & in_ready at edge N -> latch in_data, in_dest (and in_bcast) into hold register, demux_sel <= in_dest, state <= HOLD.
REQ-018 Channel k can load when out_valid[k]=0 or (out_valid[k] & out_ready[k]) in the same cycle.
REQ-019 HOLD, unicast: if channel demux_sel can load -> at next edge slot loads demux output, out_valid[sel] <= 1, disp_cnt += 1, state <= IDLE; else remain in HOLD.
REQ-020 Minimum latency: byte accepted at edge N appears on out_dataK with out_valid[k]=1 after edge N+1; peak throughput one byte per 2 cycles.
REQ-021 Slot k: out_valid[k] & out_ready[k] with no new load -> out_valid[k] <= 0, out_dataK holds last value; drain and load same cycle -> out_valid[k] stays 1 with new data.
REQ-022 Non-selected channels SHALL never be loaded by a unicast dispatch; their slots change only by their own drain.
REQ-023 Stall counter (8-bit) SHALL clear on entry to HOLD, increment each HOLD cycle without dispatch, saturate at 255.
REQ-024 stall_err SHALL set when stall counter equals STALL_MAX and remain 1 until reset; controller keeps waiting (no drop).
REQ-025 disp_cnt SHALL wrap 255 -> 0.
REQ-026 demux_sel SHALL hold its last value in IDLE.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, out_valid 4'b0000, out_data0..3 8'h00, demux_sel 2'b00, disp_cnt 8'h00, stall counter 0, stall_err 0, hold register 0.
REQ-028 Reset during HOLD SHALL discard the held byte; no slot loads; in_ready = 1 on the first cycle after rst_n rises.

Configuration
REQ-029 Macro DEMUX_BCAST_EN: defined -> a byte latched with in_bcast=1 dispatches only when all four channels can load in the same cycle, then loads all four slots with the byte, disp_cnt += 1 (once), demux_sel unchanged.
REQ-030 DEMUX_BCAST_EN undefined -> in_bcast ignored, all dispatches unicast; port remains present.

Verification
REQ-031 Reset, then in_data=8'hA5, in_dest=2, out_ready=4'b0000 -> out_valid=4'b0100, out_data2=8'hA5 one edge after accept, disp_cnt=1, in_ready=1.
REQ-032 Slot 1 full, out_ready[1]=0, send 8'h3C to dest 1 with STALL_MAX=15 -> in_ready=0, stall_err=1 after 15 stall cycles; raise out_ready[1] -> out_data1=8'h3C, state IDLE, stall_err stays 1.
REQ-033 Slot 0 full with 8'h11 and out_ready[0]=1 while 8'h22 dispatches to dest 0 -> out_valid[0] stays 1, out_data0=8'h22, no cycle with out_valid[0]=0.
REQ-034 256 back-to-back dispatches with out_ready=4'b1111 -> disp_cnt returns to 8'h00, no slot overrun.
REQ-035 rst_n pulsed low in HOLD with 8'h77 held -> all outputs at reset values, 8'h77 never appears on any out_dataK.
REQ-036 DEMUX_BCAST_EN defined, in_bcast=1, in_data=8'h5A, slot 3 full and blocked -> no load until out_ready[3]=1, then out_valid=4'b1111, all out_data=8'h5A, disp_cnt +1.
